// File: rtl/if3_redirect_if.sv
// Bundle-side bus for the IF3 redirect unit: predecoded slots in,
// trimmed valid mask and front-end redirect out.
interface if3_redirect_if #(
  parameter int FETCH_WIDTH = 4,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16
);
  logic                          flush;
  logic                          pause;
  logic [FETCH_WIDTH-1:0]        slot_valid;
  logic [FETCH_WIDTH*ADDR_W-1:0] slot_pc;
  logic [FETCH_WIDTH-1:0]        slot_is_ctrl;
  logic [FETCH_WIDTH-1:0]        pred_taken;
  logic [FETCH_WIDTH*ADDR_W-1:0] pred_target;
  logic [FETCH_WIDTH-1:0]        nlp_taken;
  logic [FETCH_WIDTH*ADDR_W-1:0] nlp_target;

  logic [FETCH_WIDTH-1:0]        out_valid;
  logic                          redirect;
  logic [ADDR_W-1:0]             redirect_pc;
  logic                          flush_req;
  logic                          wait_ds;
  logic [CNT_W-1:0]              redirect_cnt;

  modport master (
    output flush, pause, slot_valid, slot_pc, slot_is_ctrl,
           pred_taken, pred_target, nlp_taken, nlp_target,
    input  out_valid, redirect, redirect_pc, flush_req, wait_ds, redirect_cnt
  );

  modport slave (
    input  flush, pause, slot_valid, slot_pc, slot_is_ctrl,
           pred_taken, pred_target, nlp_taken, nlp_target,
    output out_valid, redirect, redirect_pc, flush_req, wait_ds, redirect_cnt
  );
endinterface

// File: rtl/if3_redirect_unit.sv
// IF3 redirect and delay-slot control: compares final vs NLP prediction per
// slot, trims the bundle and redirects fetch, deferring across a delay slot.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | normal; mismatches redirect immediately or arm WAIT_DS
// S_WAIT_DS | mispredict in last slot; waiting for the delay-slot bundle
// S_SQUASH  | drop the one wrong-path bundle already in flight
module if3_redirect_unit #(
  parameter int FETCH_WIDTH = 4,
  parameter int ADDR_W      = 32,
  parameter int DS_ENABLE   = 1,
  parameter int CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst,
  if3_redirect_if.slave  bus
);

  localparam int IDX_W    = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int DS_EXTRA = (DS_ENABLE != 0) ? 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_DS = 2'd1,
    S_SQUASH  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      saved_q, saved_d;
  logic [CNT_W-1:0]       cnt_q;

  logic [FETCH_WIDTH-1:0] mis;
  logic [ADDR_W-1:0]      fix [FETCH_WIDTH];
  logic                   hit;
  logic [IDX_W-1:0]       k;
  logic [ADDR_W-1:0]      fix_k;
  logic [FETCH_WIDTH-1:0] keep;
  logic                   last_slot;

  logic [FETCH_WIDTH-1:0] out_valid;
  logic                   redirect;
  logic [ADDR_W-1:0]      redirect_pc;

  // Per-slot mismatch and corrected target; not-taken fix resumes after the delay slot.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      logic [ADDR_W-1:0] pt;
      logic [ADDR_W-1:0] nt;
      logic [ADDR_W-1:0] pc;
      pt = bus.pred_target[i*ADDR_W +: ADDR_W];
      nt = bus.nlp_target[i*ADDR_W +: ADDR_W];
      pc = bus.slot_pc[i*ADDR_W +: ADDR_W];
      mis[i] = bus.slot_valid[i] & bus.slot_is_ctrl[i] &
               ((bus.pred_taken[i] ^ bus.nlp_taken[i]) |
                (bus.pred_taken[i] & bus.nlp_taken[i] & (pt != nt)));
      fix[i] = bus.pred_taken[i] ? pt : pc + ADDR_W'(8);
    end
  end

  always_comb begin
    hit = 1'b0;
    k   = '0;
    for (int i = FETCH_WIDTH-1; i >= 0; i--) begin
      if (mis[i]) begin
        hit = 1'b1;
        k   = i[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    keep = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      keep[i] = (i <= int'(k) + DS_EXTRA);
    end
  end

  assign fix_k     = fix[k];
  assign last_slot = (k == IDX_W'(FETCH_WIDTH-1));

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    out_valid   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    if (rst || bus.flush) begin
      state_d = S_IDLE;
      saved_d = '0;
    end else if (bus.pause) begin
      out_valid = bus.slot_valid;
    end else begin
      case (state_q)
        S_IDLE: begin
          out_valid = bus.slot_valid;
          if (hit) begin
            if (DS_ENABLE != 0 && last_slot) begin
              saved_d = fix_k;
              state_d = S_WAIT_DS;
            end else begin
              out_valid   = bus.slot_valid & keep;
              redirect    = 1'b1;
              redirect_pc = fix_k;
            end
          end
        end
        S_WAIT_DS: begin
          if (bus.slot_valid[0]) begin
            out_valid   = {{(FETCH_WIDTH-1){1'b0}}, 1'b1};
            redirect    = 1'b1;
            redirect_pc = saved_q;
            state_d     = S_SQUASH;
          end
        end
        S_SQUASH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      saved_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid    = out_valid;
  assign bus.redirect     = redirect;
  assign bus.redirect_pc  = redirect_pc;
  assign bus.flush_req    = redirect;
  assign bus.wait_ds      = (state_q == S_WAIT_DS) && !rst;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_if3_redirect_unit.sv
// Scoreboard bench for if3_redirect_unit: three configurations share one
// stimulus stream; a reference model predicts each cycle, a monitor compares.
module tb_if3_redirect_unit;
  localparam int FW = 4;
  localparam int AW = 32;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              s_flush, s_pause;
  logic [FW-1:0]     s_valid, s_ctrl, s_pt, s_nt;
  logic [FW*AW-1:0]  s_pc, s_ptgt, s_ntgt;

  if3_redirect_if #(.FETCH_WIDTH(FW), .ADDR_W(AW), .CNT_W(16)) bus0 ();
  if3_redirect_if #(.FETCH_WIDTH(FW), .ADDR_W(AW), .CNT_W(16)) bus1 ();
  if3_redirect_if #(.FETCH_WIDTH(FW), .ADDR_W(AW), .CNT_W(2))  bus2 ();

  assign bus0.flush = s_flush;  assign bus0.pause = s_pause;
  assign bus0.slot_valid = s_valid;  assign bus0.slot_pc = s_pc;
  assign bus0.slot_is_ctrl = s_ctrl;  assign bus0.pred_taken = s_pt;
  assign bus0.pred_target = s_ptgt;  assign bus0.nlp_taken = s_nt;
  assign bus0.nlp_target = s_ntgt;
  assign bus1.flush = s_flush;  assign bus1.pause = s_pause;
  assign bus1.slot_valid = s_valid;  assign bus1.slot_pc = s_pc;
  assign bus1.slot_is_ctrl = s_ctrl;  assign bus1.pred_taken = s_pt;
  assign bus1.pred_target = s_ptgt;  assign bus1.nlp_taken = s_nt;
  assign bus1.nlp_target = s_ntgt;
  assign bus2.flush = s_flush;  assign bus2.pause = s_pause;
  assign bus2.slot_valid = s_valid;  assign bus2.slot_pc = s_pc;
  assign bus2.slot_is_ctrl = s_ctrl;  assign bus2.pred_taken = s_pt;
  assign bus2.pred_target = s_ptgt;  assign bus2.nlp_taken = s_nt;
  assign bus2.nlp_target = s_ntgt;

  if3_redirect_unit #(.FETCH_WIDTH(FW), .ADDR_W(AW), .DS_ENABLE(1), .CNT_W(16))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  if3_redirect_unit #(.FETCH_WIDTH(FW), .ADDR_W(AW), .DS_ENABLE(0), .CNT_W(16))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  if3_redirect_unit #(.FETCH_WIDTH(FW), .ADDR_W(AW), .DS_ENABLE(1), .CNT_W(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [FW-1:0] ov;
    logic          rd;
    logic [AW-1:0] rpc;
    logic          wds;
    int unsigned   cnt;
  } exp_t;

  exp_t sb0[$], sb1[$], sb2[$];

  // Reference model: pending delay-slot redirect, one-shot squash, counter.
  int          m_ds  [NDUT] = '{1, 0, 1};
  int unsigned m_max [NDUT] = '{65535, 65535, 3};
  bit          m_pend[NDUT];
  bit          m_sq  [NDUT];
  logic [AW-1:0] m_saved[NDUT];
  int unsigned m_cnt [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic exp_t model_step(int j);
    exp_t e;
    int kk;
    logic [AW-1:0] fix;
    e.ov = '0; e.rd = 1'b0; e.rpc = '0;
    e.wds = m_pend[j] && !rst;
    e.cnt = m_cnt[j];
    fix = '0;
    if (rst) begin
      m_pend[j] = 0; m_sq[j] = 0; m_saved[j] = '0; m_cnt[j] = 0;
      return e;
    end
    if (s_flush) begin
      m_pend[j] = 0; m_sq[j] = 0; m_saved[j] = '0;
      return e;
    end
    if (s_pause) begin
      e.ov = s_valid;
      return e;
    end
    if (m_sq[j]) begin
      m_sq[j] = 0;
    end else if (m_pend[j]) begin
      if (s_valid[0]) begin
        e.ov = 1; e.rd = 1'b1; e.rpc = m_saved[j];
        m_pend[j] = 0; m_sq[j] = 1;
      end
    end else begin
      e.ov = s_valid;
      kk = -1;
      for (int i = 0; i < FW; i++) begin
        logic [AW-1:0] pt, nt;
        pt = s_ptgt[i*AW +: AW];
        nt = s_ntgt[i*AW +: AW];
        if (kk < 0 && s_valid[i] && s_ctrl[i] &&
            (s_pt[i] != s_nt[i] || (s_pt[i] && pt != nt))) begin
          kk = i;
          fix = s_pt[i] ? pt : s_pc[i*AW +: AW] + 32'd8;
        end
      end
      if (kk >= 0) begin
        if (kk == FW-1 && m_ds[j] != 0) begin
          m_pend[j] = 1; m_saved[j] = fix;
        end else begin
          for (int i = 0; i < FW; i++)
            if (i > kk + m_ds[j]) e.ov[i] = 1'b0;
          e.rd = 1'b1; e.rpc = fix;
        end
      end
    end
    if (e.rd && m_cnt[j] < m_max[j]) m_cnt[j]++;
    return e;
  endfunction

  task automatic chk(string nm, int j, logic [AW-1:0] act, logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t got %h want %h", nm, j, $time, act, exp);
    end
  endtask

  task automatic compare(int j, exp_t e, logic [FW-1:0] ov, logic rd, logic [AW-1:0] rpc,
                         logic fr, logic wds, logic [15:0] cnt);
    chk("out_valid", j, AW'(ov), AW'(e.ov));
    chk("redirect", j, AW'(rd), AW'(e.rd));
    chk("redirect_pc", j, rpc, e.rpc);
    chk("flush_req", j, AW'(fr), AW'(e.rd));
    chk("wait_ds", j, AW'(wds), AW'(e.wds));
    chk("redirect_cnt", j, AW'(cnt), AW'(e.cnt));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      compare(0, e, bus0.out_valid, bus0.redirect, bus0.redirect_pc,
              bus0.flush_req, bus0.wait_ds, bus0.redirect_cnt);
    end
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      compare(1, e, bus1.out_valid, bus1.redirect, bus1.redirect_pc,
              bus1.flush_req, bus1.wait_ds, bus1.redirect_cnt);
    end
    if (sb2.size() > 0) begin
      e = sb2.pop_front();
      compare(2, e, bus2.out_valid, bus2.redirect, bus2.redirect_pc,
              bus2.flush_req, bus2.wait_ds, 16'(bus2.redirect_cnt));
    end
  end

  task automatic begin_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic commit();
    sb0.push_back(model_step(0));
    sb1.push_back(model_step(1));
    sb2.push_back(model_step(2));
  endtask

  task automatic clear_bundle(logic [AW-1:0] base);
    rst = 1'b0; s_flush = 1'b0; s_pause = 1'b0;
    s_valid = '1; s_ctrl = '0; s_pt = '0; s_nt = '0;
    s_ptgt = '0; s_ntgt = '0;
    for (int i = 0; i < FW; i++) s_pc[i*AW +: AW] = base + 32'(4*i);
  endtask

  task automatic set_slot(int i, logic pt, logic [AW-1:0] ptgt, logic nt, logic [AW-1:0] ntgt);
    s_ctrl[i] = 1'b1; s_pt[i] = pt; s_nt[i] = nt;
    s_ptgt[i*AW +: AW] = ptgt;
    s_ntgt[i*AW +: AW] = ntgt;
  endtask

  task automatic cyc();
    commit();
    begin_cycle();
  endtask

  task automatic arm_ds();
    clear_bundle(32'h1F0);
    set_slot(3, 1'b1, 32'h2000, 1'b1, 32'h3000);
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    clear_bundle(32'h0);
    for (int j = 0; j < NDUT; j++) begin
      m_pend[j] = 0; m_sq[j] = 0; m_saved[j] = '0; m_cnt[j] = 0;
    end
    begin_cycle();
    rst = 1'b1; cyc();
    rst = 1'b1; cyc();

    // taken correction at slot 1, then not-taken correction at slot 0
    clear_bundle(32'h100); set_slot(1, 1'b1, 32'h1000, 1'b0, 32'h0); cyc();
    clear_bundle(32'h400); set_slot(0, 1'b0, 32'h0, 1'b1, 32'h999); cyc();
    clear_bundle(32'h500); cyc();

    // delay slot spanning bundles, with an ignored mismatch while waiting
    arm_ds();
    clear_bundle(32'h200); s_valid = '0; cyc();
    clear_bundle(32'h200); set_slot(1, 1'b1, 32'h7777, 1'b0, 32'h0); cyc();
    clear_bundle(32'h210); set_slot(0, 1'b1, 32'h5555, 1'b0, 32'h0); cyc();
    clear_bundle(32'h2000); cyc();

    // flush while waiting for the delay slot
    arm_ds();
    clear_bundle(32'h200); s_flush = 1'b1; cyc();
    clear_bundle(32'h300); cyc();

    // pause while waiting, then release; pause during squash
    arm_ds();
    clear_bundle(32'h200); s_pause = 1'b1; cyc();
    clear_bundle(32'h200); s_pause = 1'b1; cyc();
    clear_bundle(32'h200); cyc();
    clear_bundle(32'h210); s_pause = 1'b1; cyc();
    clear_bundle(32'h210); cyc();
    clear_bundle(32'h2000); cyc();

    // flush racing a mismatch
    clear_bundle(32'h600); set_slot(0, 1'b1, 32'hABC0, 1'b0, 32'h0); s_flush = 1'b1; cyc();

    // five back-to-back redirects saturate the 2-bit counter
    for (int n = 0; n < 5; n++) begin
      clear_bundle(32'h800 + 32'(n*16)); set_slot(2, 1'b0, 32'h0, 1'b1, 32'h44); cyc();
    end

    // PC wrap on not-taken fix, and reset from WAIT_DS
    clear_bundle(32'hFFFF_FFF0); set_slot(3, 1'b0, 32'h0, 1'b1, 32'h88); cyc();
    clear_bundle(32'hFFFF_FFF0); set_slot(1, 1'b0, 32'h0, 1'b1, 32'h88); cyc();
    arm_ds();
    clear_bundle(32'h0); rst = 1'b1; cyc();
    clear_bundle(32'h0); cyc();

    for (int n = 0; n < 3000; n++) begin
      clear_bundle(32'($urandom) & 32'hFFFF_FFF0);
      if ($urandom_range(0, 3) == 0) s_valid = FW'($urandom);
      for (int i = 0; i < FW; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          set_slot(i, 1'($urandom), $urandom_range(0, 1) ? 32'h1000 : 32'h2000,
                   1'($urandom), $urandom_range(0, 1) ? 32'h1000 : 32'h2000);
          if ($urandom_range(0, 7) == 0) s_ptgt[i*AW +: AW] = $urandom;
        end
      end
      s_pause = ($urandom_range(0, 7) == 0);
      s_flush = ($urandom_range(0, 24) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      cyc();
    end

    clear_bundle(32'h0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb0.size() + sb1.size() + sb2.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sb0.size() + sb1.size() + sb2.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/if3_redirect_unit.md
Name: if3_redirect_unit

Overview:
- N-wide generalisation of fetch stage 3 redirect and delay-slot control.
- Takes a predecoded fetch bundle of FETCH_WIDTH slots, compares the final prediction (BPD/predecode) against the NLP prediction per slot, and trims the bundle.
- Issues a front-end redirect/flush, and tracks a pending MIPS delay slot across bundle boundaries through a small FSM.
- Sits between the predecoder/BPD merge logic and the IF3 output registers.

Parameters:
- FETCH_WIDTH, 4, slots per bundle; power of two, 2..8.
- ADDR_W, 32, PC/target width.
- DS_ENABLE, 1, 1 = branch delay slot architecture; 0 = no delay slot (WAIT_DS is never entered).
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush from backend
- pause  in  1  stall of this stage
- slot_valid  in  FETCH_WIDTH  per-slot valid
- slot_pc  in  FETCH_WIDTH*ADDR_W  per-slot PC, slot i at bits [i*ADDR_W +: ADDR_W]
- slot_is_ctrl  in  FETCH_WIDTH  slot is a j/jr/branch
- pred_taken  in  FETCH_WIDTH  final prediction taken
- pred_target  in  FETCH_WIDTH*ADDR_W  final predicted target
- nlp_taken  in  FETCH_WIDTH  NLP predicted taken (already qualified by nlp valid)
- nlp_target  in  FETCH_WIDTH*ADDR_W  NLP target
- out_valid  out  FETCH_WIDTH  trimmed slot valid mask
- redirect  out  1  redirect fetch this cycle
- redirect_pc  out  ADDR_W  redirect target
- flush_req  out  1  flush IF1/IF2; equals redirect
- wait_ds  out  1  FSM in WAIT_DS
- redirect_cnt  out  CNT_W  saturating count of asserted redirects

Behaviour:
- Reset: rst is synchronous active-high; clock clk. On reset the FSM goes to IDLE, the saved target and redirect_cnt clear to 0, and all combinational outputs are 0 while rst is high.
- Priority: rst > flush > pause > FSM action. flush acts like reset except that redirect_cnt is kept. During pause, state holds, redirect=0 and out_valid=slot_valid.
- Mismatch at slot i: slot_valid[i] & slot_is_ctrl[i], and any of:
  - (pred_taken & !nlp_taken)
  - (!pred_taken & nlp_taken)
  - (pred_taken & nlp_taken & pred_target != nlp_target)
- Fix target: pred_taken ? pred_target[i] : slot_pc[i]+8 (mod 2^ADDR_W).
- Let k be the lowest index with a mismatch. Combinational redirect path, zero latency.
- States IDLE, WAIT_DS, SQUASH.
- IDLE, no mismatch: out_valid=slot_valid, redirect=0, stay IDLE.
- IDLE, mismatch at k < FETCH_WIDTH-1 (or DS_ENABLE=0):
  - Keep slots 0..k+1 (DS_ENABLE=1) or 0..k (DS_ENABLE=0); clear the rest.
  - Redirect this cycle to the fix target; stay IDLE.
- IDLE, mismatch at k = FETCH_WIDTH-1 with DS_ENABLE=1:
  - out_valid=slot_valid, redirect=0.
  - Save the fix target; next state WAIT_DS.
- WAIT_DS, slot_valid[0]=0: hold; redirect=0; out_valid=0.
- WAIT_DS, slot_valid[0]=1: out_valid=0...01 (delay slot only); redirect=1 to the saved target; next state SQUASH.
- SQUASH: out_valid=0, redirect=0; lasts exactly one unpaused cycle, then IDLE. This kills the in-flight wrong-path bundle.
- Mismatches in incoming slots are ignored while in WAIT_DS or SQUASH.
- redirect_cnt increments by 1 on each cycle with redirect=1 and saturates at all-ones.
- flush in WAIT_DS drops the saved target with no redirect.
- Simultaneous flush and mismatch: flush wins; redirect=0.

Test Plan:
- Mismatch at slot 1: FETCH_WIDTH=4, valid=1111, slot1 ctrl, pred_taken=1 to 0x1000, nlp_taken=0 → out_valid=0111, redirect=1, redirect_pc=0x1000 same cycle, redirect_cnt=1.
- Not-taken correction: slot0 pc=0x400, pred_taken=0, nlp_taken=1 → out_valid=0011, redirect_pc=0x408.
- Delay slot across bundles: slot3 target mismatch (pred 0x2000, nlp 0x3000) → no redirect, wait_ds=1. Next cycle valid=0000 → hold. Next valid=1111 → out_valid=0001, redirect_pc=0x2000. Following cycle out_valid=0000, then IDLE.
- DS_ENABLE=0, mismatch at slot3 → immediate redirect, out_valid=1111, wait_ds stays 0.
- Interference: flush during WAIT_DS → IDLE next cycle, no redirect, redirect_cnt unchanged. pause during WAIT_DS with valid slot0 → redirect=0, state held until pause drops.
- Counter: CNT_W=2, 5 redirects → redirect_cnt=3. rst=1 → all outputs 0 next cycle.
